// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: register-mapped I2C target exposing a REG_NUM x 8-bit register file.
// The bus is oversampled on clk; scl is only observed, sda is open-drain (0 or z).
//
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   scl          bus clock (input only)
//   sda          bus data, open-drain
//   host_addr    host read index (low log2(REG_NUM) bits used)
//   host_rdata   combinational read of regs[host_addr]
//   wr_stb       one-cycle pulse when a bus write commits a register
//   wr_addr      committed register index (valid with wr_stb)
//   wr_data      committed register value (valid with wr_stb)
//   busy         addressed transfer in progress
//
// Build option: define I2C_REG_SLV_GLITCH_FLT_EN to add a 3-sample majority filter on
// the synchronized scl/sda samples.
module i2c_reg_slave #(
    parameter logic [6:0]  SLV_ADDR = 7'h2d,
    parameter int unsigned REG_NUM  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    input  logic [3:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       wr_stb,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    localparam int unsigned PtrW = $clog2(REG_NUM);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRdataAck, StWait
    } state_e;

    // Input synchronizers; reset to the idle-bus level so no false edge follows reset.
    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_s, sda_s;
    logic       scl_r, sda_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
        end
    end

`ifdef I2C_REG_SLV_GLITCH_FLT_EN
    logic [2:0] scl_hist_q, sda_hist_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist_q <= 3'b111;
            sda_hist_q <= 3'b111;
        end else begin
            scl_hist_q <= {scl_hist_q[1:0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[1:0], sda_sync_q[1]};
        end
    end
    assign scl_s = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
                   (scl_hist_q[1] & scl_hist_q[2]);
    assign sda_s = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
                   (sda_hist_q[1] & sda_hist_q[2]);
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_r <= 1'b1;
            sda_r <= 1'b1;
        end else begin
            scl_r <= scl_s;
            sda_r <= sda_s;
        end
    end

    logic scl_rise, scl_fall, start, stop;
    assign scl_rise = scl_s & ~scl_r;
    assign scl_fall = ~scl_s & scl_r;
    assign start    = scl_s & scl_r & sda_r & ~sda_s;
    assign stop     = scl_s & scl_r & ~sda_r & sda_s;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [7:0]      sh_q, sh_d;
    logic [PtrW-1:0] ptr_q, ptr_d, ptr_inc;
    logic            rw_q, rw_d, full_q, full_d, nack_q, nack_d;
    logic            oe_q, oe_d, busy_q, busy_d;
    logic            wr_stb_q, wr_stb_d;
    logic [3:0]      wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            reg_we;
    logic [7:0]      rx_byte;
    logic [7:0]      regs_q [REG_NUM];

    assign ptr_inc = ptr_q + PtrW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        full_d    = full_q;
        nack_d    = nack_q;
        oe_d      = oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;
        rx_byte   = {sh_q[6:0], sda_s};

        if (stop) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start) begin
            // START wins over a coincident data edge; the pointer is kept.
            state_d = StAddr;
            cnt_d   = 3'd0;
            full_d  = 1'b0;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise && !full_q) begin
                        sh_d  = rx_byte;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            full_d = 1'b1;
                            if (state_q == StAddr) begin
                                if (rx_byte[7:1] == SLV_ADDR) begin
                                    rw_d   = rx_byte[0];
                                    busy_d = 1'b1;
                                end else begin
                                    state_d = StWait;
                                    full_d  = 1'b0;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == StPtr) begin
                                ptr_d = rx_byte[PtrW-1:0];
                            end else begin
                                reg_we    = 1'b1;
                                wr_stb_d  = 1'b1;
                                wr_addr_d = 4'(ptr_q);
                                wr_data_d = rx_byte;
                                ptr_d     = ptr_inc;
                            end
                        end
                    end else if (scl_fall && full_q) begin
                        // Bit 8 ended: pull sda low for the ACK slot.
                        full_d = 1'b0;
                        oe_d   = 1'b1;
                        state_d = (state_q == StAddr) ? StAddrAck :
                                  (state_q == StPtr)  ? StPtrAck  : StWdataAck;
                    end
                end
                StAddrAck, StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        oe_d  = 1'b0;
                        cnt_d = 3'd0;
                        if (state_q == StAddrAck && rw_q) begin
                            state_d = StRdata;
                            sh_d    = regs_q[ptr_q];
                            oe_d    = ~regs_q[ptr_q][7];
                        end else if (state_q == StAddrAck) begin
                            state_d = StPtr;
                        end else begin
                            state_d = StWdata;
                        end
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        if (cnt_q == 3'd7) begin
                            oe_d    = 1'b0;
                            cnt_d   = 3'd0;
                            state_d = StRdataAck;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            sh_d  = {sh_q[6:0], 1'b0};
                            oe_d  = ~sh_q[6];
                        end
                    end
                end
                StRdataAck: begin
                    if (scl_rise) begin
                        nack_d = sda_s;
                    end else if (scl_fall) begin
                        if (!nack_q) begin
                            ptr_d   = ptr_inc;
                            sh_d    = regs_q[ptr_inc];
                            oe_d    = ~regs_q[ptr_inc][7];
                            state_d = StRdata;
                        end else begin
                            state_d = StWait;
                            busy_d  = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 3'd0;
            sh_q      <= 8'h00;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            full_q    <= 1'b0;
            nack_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 4'h0;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            full_q    <= full_d;
            nack_q    <= nack_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) regs_q[i] <= 8'h00;
        end else if (reg_we) begin
            regs_q[ptr_q] <= wr_data_d;
        end
    end

    // oe_q is asynchronously cleared, so reset releases sda immediately.
    assign sda        = oe_q ? 1'b0 : 1'bz;
    assign host_rdata = regs_q[host_addr[PtrW-1:0]];
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule
